sha3_pad_absorb: RTL and testbench



---
 rtl/sha3_pad_absorb.sv | 128 ++++++++++++
 tb/tb_sha3_pad_absorb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sha3_pad_absorb.sv
// sha3_pad_absorb: pops 64-bit message lanes, masks the tail, applies pad10*1 with a domain byte, and emits rate-sized blocks
// Ports: clk/reset_n (async active-low); start+msg_len begin a message; fifo_data/fifo_empty/fifo_rd read lanes;
// blk_data/blk_valid/blk_ready/blk_last hand blocks to the permutation core; busy while a message is in flight; done pulses at the end.
// Optional: define SHA3_PAD_XOF_EN to add xof_mode (domain byte 0x1F instead of 0x06).
module sha3_pad_absorb #(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef SHA3_PAD_XOF_EN
  input  logic                        xof_mode,
`endif
  input  logic                        start,
  input  logic [LEN_W-1:0]            msg_len,
  input  logic [WIDTH-1:0]            fifo_data,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  output logic [RATE_LANES*WIDTH-1:0] blk_data,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic                        blk_last,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(RATE_LANES + 1);
  localparam logic [CW-1:0] FULL = CW'(RATE_LANES);
  localparam int BB = RATE_LANES * WIDTH / 8;
  typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, FIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, words_q, words_d, wcap_q, wcap_d, w;
  logic [CW-1:0] lanes_q, lanes_d, cap_q, cap_d;
  logic pend_q, pend_d, last_q, last_d;
  logic [7:0] dom_q, dom_d;
  logic [RATE_LANES*WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] keep;
  int pos;
  assign w = (len_q >> 3) + LEN_W'(|len_q[2:0]);
  // only the final word of a message with a partial tail keeps its low L%8 bytes
  assign keep = (wcap_q == w - LEN_W'(1) && len_q[2:0] != 3'd0) ?
                (WIDTH'(1) << {len_q[2:0], 3'b000}) - WIDTH'(1) : '1;
  // byte just past the message within the current block; 0 for an empty extra block
  assign pos = (len_q[2:0] != 3'd0) ? (int'(cap_q) - 1) * 8 + int'(len_q[2:0]) : int'(cap_q) * 8;
  assign fifo_rd = state_q == FILL && !fifo_empty && words_q < w && lanes_q < FULL;
  assign blk_data = buf_q;
  assign blk_valid = state_q == SEND;
  assign blk_last = last_q;
  assign busy = state_q inside {FILL, PAD, SEND};
  assign done = state_q == FIN;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    words_d = words_q + LEN_W'(fifo_rd);
    lanes_d = lanes_q + CW'(fifo_rd);
    wcap_d = wcap_q;
    cap_d = cap_q;
    pend_d = fifo_rd;
    last_d = last_q;
    dom_d = dom_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (start) begin
        len_d = msg_len;
        words_d = '0;
        wcap_d = '0;
        lanes_d = '0;
        cap_d = '0;
        last_d = 1'b0;
        buf_d = '0;
`ifdef SHA3_PAD_XOF_EN
        dom_d = xof_mode ? 8'h1F : 8'h06;
`else
        dom_d = 8'h06;
`endif
        state_d = (msg_len == '0) ? PAD : FILL;
      end
      FILL: if (pend_q) begin
        buf_d[int'(cap_q)*WIDTH +: WIDTH] = fifo_data & keep;
        cap_d = cap_q + CW'(1);
        wcap_d = wcap_q + LEN_W'(1);
        // a full block whose last lane is complete leaves no room for padding
        if (wcap_d == w) state_d = (cap_d == FULL && len_q[2:0] == 3'd0) ? SEND : PAD;
        else if (cap_d == FULL) state_d = SEND;
      end
      PAD: begin
        buf_d[pos*8 +: 8] = buf_d[pos*8 +: 8] ^ dom_q;
        buf_d[(BB-1)*8 +: 8] = buf_d[(BB-1)*8 +: 8] ^ 8'h80;
        last_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (blk_ready) begin
        buf_d = '0;
        lanes_d = '0;
        cap_d = '0;
        last_d = 1'b0;
        state_d = last_q ? FIN : (wcap_q == w) ? PAD : FILL;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q <= '0;
      words_q <= '0;
      wcap_q <= '0;
      lanes_q <= '0;
      cap_q <= '0;
      pend_q <= 1'b0;
      last_q <= 1'b0;
      dom_q <= 8'h06;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      words_q <= words_d;
      wcap_q <= wcap_d;
      lanes_q <= lanes_d;
      cap_q <= cap_d;
      pend_q <= pend_d;
      last_q <= last_d;
      dom_q <= dom_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: tb/tb_sha3_pad_absorb.sv
// tb_sha3_pad_absorb: drives messages through a FIFO model and checks blocks against a byte-level padding model
module tb_sha3_pad_absorb;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, fifo_empty = 1'b1, blk_ready = 1'b0, xof = 1'b0;
  logic [31:0] msg_len = '0;
  logic [63:0] fifo_data = '0;
  logic fifo_rd, blk_valid, blk_last, busy, done;
  logic [1087:0] blk_data;
  logic [63:0] fq[$];
  int rd_cnt = 0, bad_rd = 0, errors = 0, checks = 0;
  bit tog = 1'b0, tog_ph = 1'b0;
  sha3_pad_absorb dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SHA3_PAD_XOF_EN
    .xof_mode(xof),
`endif
    .start(start), .msg_len(msg_len), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_last(blk_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_cnt++;
      if (fifo_empty || fq.size() == 0) bad_rd++;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
  end
  always @(negedge clk) begin
    tog_ph = ~tog_ph;
    fifo_empty = (fq.size() == 0) || (tog && tog_ph);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_lanes(input string tag, input logic [1087:0] exp);
    for (int l = 0; l < 17; l++) chk($sformatf("%s lane%0d", tag, l), blk_data[l*64 +: 64], exp[l*64 +: 64]);
  endtask
  task automatic run_msg(input int len, input int mode, input bit stall, input bit tg,
                         input bit kc, input logic [63:0] k0, input logic [63:0] k16);
    logic [7:0] m[$];
    logic [7:0] p[$];
    logic [1087:0] blks[$];
    logic [1087:0] blk;
    logic [63:0] wd;
    int nb, w, cyc;
    for (int k = 0; k < len; k++) m.push_back(mode == 0 ? 8'($urandom) : mode == 1 ? 8'hFF : 8'(8'h61 + k));
    w = (len + 7) / 8;
    for (int i = 0; i < w; i++) begin
      for (int b = 0; b < 8; b++) wd[8*b +: 8] = (8*i + b < len) ? m[8*i + b] : (mode == 0 ? 8'($urandom) : 8'hFF);
      fq.push_back(wd);
    end
    nb = len / 136 + 1;
    for (int i = 0; i < nb * 136; i++) p.push_back(i < len ? m[i] : 8'h00);
    p[len] = p[len] ^ 8'h06;
    p[nb*136-1] = p[nb*136-1] ^ 8'h80;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 136; k++) blk[8*k +: 8] = p[b*136 + k];
      blks.push_back(blk);
    end
    rd_cnt = 0;
    bad_rd = 0;
    tog = tg;
    @(negedge clk);
    msg_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("L%0d busy", len), busy, 1);
    for (int b = 0; b < nb; b++) begin
      cyc = 0;
      while (!blk_valid && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("L%0d b%0d valid", len, b), blk_valid, 1);
      chk($sformatf("L%0d b%0d last", len, b), blk_last, (b == nb - 1) ? 1 : 0);
      chk_lanes($sformatf("L%0d b%0d", len, b), blks[b]);
      if (kc && b == nb - 1) begin
        chk($sformatf("L%0d k0", len), blk_data[63:0], k0);
        chk($sformatf("L%0d k16", len), blk_data[1087:1024], k16);
      end
      if (stall) begin
        repeat (5) @(negedge clk);
        chk($sformatf("L%0d b%0d hold valid", len, b), blk_valid, 1);
        chk($sformatf("L%0d b%0d hold last", len, b), blk_last, (b == nb - 1) ? 1 : 0);
        chk_lanes($sformatf("L%0d b%0d hold", len, b), blks[b]);
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      chk($sformatf("L%0d b%0d valid drop", len, b), blk_valid, 0);
      chk($sformatf("L%0d b%0d done", len, b), done, (b == nb - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk($sformatf("L%0d done low", len), done, 0);
    chk($sformatf("L%0d idle", len), busy, 0);
    chk($sformatf("L%0d rd count", len), 64'(rd_cnt), 64'(w));
    chk($sformatf("L%0d bad rd", len), 64'(bad_rd), 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " fifo_rd"}, fifo_rd, 0);
    chk({tag, " valid"}, blk_valid, 0);
    chk({tag, " last"}, blk_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " data"}, 64'(|blk_data), 0);
  endtask
  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset_n = 1'b1;
    @(negedge clk);
    run_msg(0, 0, 0, 0, 1, 64'h6, 64'h8000000000000000);
    run_msg(3, 2, 0, 0, 1, 64'h0000000006636261, 64'h8000000000000000);
    run_msg(135, 1, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'h86FFFFFFFFFFFFFF);
    run_msg(136, 0, 1, 0, 1, 64'h6, 64'h8000000000000000);
    run_msg(40, 0, 0, 1, 0, 0, 0);
    run_msg(272, 0, 0, 1, 0, 0, 0);
    run_msg(137, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) fq.push_back({$urandom, $urandom});
    rd_cnt = 0;
    @(negedge clk);
    msg_len = 800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rd_cnt < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid rd reached", 64'(rd_cnt), 3);
    reset_n = 1'b0;
    #1;
    chk_reset("mid");
    @(negedge clk);
    chk_reset("mid hold");
    fq.delete();
    reset_n = 1'b1;
    run_msg(8, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) run_msg($urandom_range(1, 300), 0, 1'($urandom), 1'($urandom), 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
